bin2bcd_seq: RTL and testbench



---
 rtl/disp_pkg.sv | 26 ++
 rtl/bcd_digit_adj.sv | 17 +
 rtl/bin2bcd_seq.sv | 118 +++++++++++
 tb/tb_bin2bcd_seq.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: shared display types for the counter-to-seg_driver path.
// Holds BCD digit types, the converter state enum and the pow10 helper.
package disp_pkg;

   localparam int DISP_DIGITS = 6;

   typedef logic [3:0] bcd_digit_t;
   typedef bcd_digit_t [DISP_DIGITS-1:0] bcd_vec_t;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LATCH
   } bin2bcd_state_e;

   // 10**n as a 64-bit constant, used for the overflow threshold.
   function automatic logic [63:0] pow10(input int unsigned n);
      logic [63:0] r;
      r = 64'd1;
      for (int unsigned i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 when digit >= 5.
// Ports: d = BCD digit in, q = corrected digit (4-bit, carry dropped).
module bcd_digit_adj
   import disp_pkg::*;
(
   input  bcd_digit_t d,
   output bcd_digit_t q
);

   always_comb begin
      q = d;
      if (d >= 4'd5) begin
         q = d + 4'd3;
      end
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter, one bit per clock.
// Ports: clk, rstn (async low), start_i/bin_i in; busy_o, done_o,
// bcd_o (digit k at [k*4+:4]), ovf_o, digit_valid_o out.
// Optional macro BIN2BCD_BLANK_EN enables leading-zero blanking.
module bin2bcd_seq
   import disp_pkg::*;
#(
   parameter int BIN_W  = 20,
   parameter int DIGITS = DISP_DIGITS
)
(
   input  logic                clk,
   input  logic                rstn,
   input  logic                start_i,
   input  logic [BIN_W-1:0]    bin_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [DIGITS*4-1:0] bcd_o,
   output logic                ovf_o,
   output logic [DIGITS-1:0]   digit_valid_o
);

   localparam int BCD_W = DIGITS * 4;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

   bin2bcd_state_e   state;
   logic [BIN_W-1:0] bin_sr;
   logic [BCD_W-1:0] bcd_sr;
   logic [BCD_W-1:0] bcd_adj;
   logic [BCD_W-1:0] bcd_fin;
   logic [CNT_W-1:0] cnt;
   logic             ovf_q;

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
         .d (bcd_sr[gi*4 +: 4]),
         .q (bcd_adj[gi*4 +: 4])
      );
   end

   // Overflowed values display as all nines.
   assign bcd_fin = ovf_q ? {DIGITS{4'd9}} : bcd_sr;

`ifdef BIN2BCD_BLANK_EN
   logic [DIGITS-1:0] blank_v;
   logic              seen;

   // Scan from the top digit: a digit shows once any digit at or
   // above it is nonzero. Digit 0 always shows.
   always_comb begin
      blank_v = '0;
      seen    = 1'b0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         seen       = seen | (bcd_fin[k*4 +: 4] != 4'd0);
         blank_v[k] = seen;
      end
      blank_v[0] = 1'b1;
   end
`else
   assign digit_valid_o = '1;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= IDLE;
         busy_o <= 1'b0;
         done_o <= 1'b0;
         bcd_o  <= '0;
         ovf_o  <= 1'b0;
         cnt    <= '0;
         bin_sr <= '0;
         bcd_sr <= '0;
         ovf_q  <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
         digit_valid_o <= '1;
`endif
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  bin_sr <= bin_i;
                  bcd_sr <= '0;
                  ovf_q  <= 64'(bin_i) > MAX_VAL;
                  cnt    <= '0;
                  busy_o <= 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               // Top-digit carry is dropped; ovf_q covers it.
               bcd_sr <= {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
               bin_sr <= bin_sr << 1;
               cnt    <= cnt + CNT_W'(1);
               if (cnt == LAST) begin
                  state <= LATCH;
               end
            end
            LATCH: begin
               bcd_o  <= bcd_fin;
               ovf_o  <= ovf_q;
               done_o <= 1'b1;
               busy_o <= 1'b0;
               state  <= IDLE;
`ifdef BIN2BCD_BLANK_EN
               digit_valid_o <= blank_v;
`endif
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: self-checking bench for bin2bcd_seq.
// Checks against a decimal arithmetic model; honours BIN2BCD_BLANK_EN.
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start_i = 1'b0;
   logic [19:0] bin_i = '0;
   logic        busy_o;
   logic        done_o;
   logic [23:0] bcd_o;
   logic        ovf_o;
   logic [5:0]  digit_valid_o;

   int checks = 0;
   int failures = 0;

   bin2bcd_seq #(.BIN_W(20), .DIGITS(6)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .start_i       (start_i),
      .bin_i         (bin_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .bcd_o         (bcd_o),
      .ovf_o         (ovf_o),
      .digit_valid_o (digit_valid_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   function automatic logic [23:0] exp_bcd(input int unsigned v);
      logic [23:0] r;
      int unsigned t;
      if (v > 999999) return 24'h999999;
      r = '0;
      t = v;
      for (int k = 0; k < 6; k++) begin
         r[k*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic exp_ovf(input int unsigned v);
      return v > 999999;
   endfunction

   function automatic logic [5:0] exp_dv(input int unsigned v);
`ifdef BIN2BCD_BLANK_EN
      logic [5:0] r;
      int unsigned p;
      if (v > 999999) return 6'b111111;
      r = 6'b000001;
      p = 10;
      for (int k = 1; k < 6; k++) begin
         r[k] = (v / p) != 0;
         p = p * 10;
      end
      return r;
`else
      return (v > 0) ? 6'b111111 : 6'b111111;
`endif
   endfunction

   // Runs one conversion; reports latency from accept and any cycle
   // where busy dropped or the held result moved before done.
   task automatic convert(input logic [19:0] v, output int lat,
                          output int busy_bad, output int stable_bad);
      logic [23:0] prev;
      logic        prev_ovf;
      @(negedge clk);
      prev     = bcd_o;
      prev_ovf = ovf_o;
      start_i  = 1'b1;
      bin_i    = v;
      @(posedge clk);
      @(negedge clk);
      start_i    = 1'b0;
      bin_i      = 20'($urandom);
      lat        = 0;
      busy_bad   = 0;
      stable_bad = 0;
      while (!done_o && lat < 40) begin
         if (!busy_o) busy_bad++;
         if (bcd_o !== prev || ovf_o !== prev_ovf) stable_bad++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctl got busy=%b done=%b exp 0 0",
                  busy_o, done_o);
      end
      checks++;
      if (bcd_o !== 24'h0 || ovf_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_data got bcd=%h ovf=%b exp 000000 0",
                  bcd_o, ovf_o);
      end
      checks++;
      if (digit_valid_o !== 6'b111111) begin
         failures++;
         $display("FAIL reset_dv got=%b exp=111111", digit_valid_o);
      end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_basic();
      int lat, bb, sb;
      convert(20'd123456, lat, bb, sb);
      checks++;
      if (lat != 21) begin
         failures++;
         $display("FAIL basic_latency got=%0d exp=21", lat);
      end
      checks++;
      if (bb != 0 || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL basic_busy bad_cycles=%0d busy_at_done=%b exp 0 0",
                  bb, busy_o);
      end
      checks++;
      if (sb != 0) begin
         failures++;
         $display("FAIL basic_hold got=%0d moves exp=0", sb);
      end
      checks++;
      if (bcd_o !== 24'h123456 || ovf_o !== 1'b0) begin
         failures++;
         $display("FAIL basic_value got=%h ovf=%b exp=123456 ovf=0",
                  bcd_o, ovf_o);
      end
      checks++;
      if (digit_valid_o !== exp_dv(123456)) begin
         failures++;
         $display("FAIL basic_dv got=%b exp=%b",
                  digit_valid_o, exp_dv(123456));
      end
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0 || bcd_o !== 24'h123456) begin
         failures++;
         $display("FAIL basic_pulse got done=%b bcd=%h exp 0 123456",
                  done_o, bcd_o);
      end
   endtask

   task automatic test_boundary();
      int unsigned tbl[8] = '{0, 999999, 1000000, 1048575,
                              9, 10, 99999, 100000};
      int lat, bb, sb;
      foreach (tbl[i]) begin
         convert(20'(tbl[i]), lat, bb, sb);
         checks++;
         if (lat != 21 || bb != 0 || sb != 0) begin
            failures++;
            $display("FAIL bound_timing v=%0d lat=%0d busy=%0d hold=%0d",
                     tbl[i], lat, bb, sb);
         end
         checks++;
         if (bcd_o !== exp_bcd(tbl[i]) || ovf_o !== exp_ovf(tbl[i])) begin
            failures++;
            $display("FAIL bound_value v=%0d got=%h/%b exp=%h/%b",
                     tbl[i], bcd_o, ovf_o, exp_bcd(tbl[i]),
                     exp_ovf(tbl[i]));
         end
         checks++;
         if (digit_valid_o !== exp_dv(tbl[i])) begin
            failures++;
            $display("FAIL bound_dv v=%0d got=%b exp=%b",
                     tbl[i], digit_valid_o, exp_dv(tbl[i]));
         end
      end
   endtask

   task automatic test_random();
      int unsigned v;
      int lat, bb, sb;
      for (int i = 0; i < 24; i++) begin
         if (i % 3 == 0) v = $urandom_range(0, 20'hFFFFF);
         else if (i % 3 == 1) v = $urandom_range(0, 999);
         else v = $urandom_range(0, 999999);
         convert(20'(v), lat, bb, sb);
         checks++;
         if (lat != 21 || bcd_o !== exp_bcd(v) || ovf_o !== exp_ovf(v)
             || digit_valid_o !== exp_dv(v)) begin
            failures++;
            $display("FAIL rand v=%0d lat=%0d got=%h/%b/%b exp=%h/%b/%b",
                     v, lat, bcd_o, ovf_o, digit_valid_o,
                     exp_bcd(v), exp_ovf(v), exp_dv(v));
         end
      end
   endtask

   task automatic test_ignore_start();
      int n;
      @(negedge clk);
      start_i = 1'b1;
      bin_i   = 20'd42;
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
      n = 0;
      while (!done_o && n < 40) begin
         start_i = (n == 5);
         bin_i   = (n == 5) ? 20'd7 : 20'd0;
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 21 || bcd_o !== 24'h000042 || ovf_o !== 1'b0) begin
         failures++;
         $display("FAIL ignore got lat=%0d bcd=%h ovf=%b exp 21 000042 0",
                  n, bcd_o, ovf_o);
      end
      checks++;
      if (digit_valid_o !== exp_dv(42)) begin
         failures++;
         $display("FAIL ignore_dv got=%b exp=%b",
                  digit_valid_o, exp_dv(42));
      end
      // Request in the done cycle must be taken at the next edge.
      start_i = 1'b1;
      bin_i   = 20'd7;
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
      bin_i   = 20'd0;
      n = 0;
      while (!done_o && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 21 || bcd_o !== 24'h000007) begin
         failures++;
         $display("FAIL done_cycle_start got lat=%0d bcd=%h exp 21 000007",
                  n, bcd_o);
      end
   endtask

   task automatic test_back_to_back();
      int unsigned v;
      int n;
      @(negedge clk);
      start_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         v     = $urandom_range(0, 20'hFFFFF);
         bin_i = 20'(v);
         @(posedge clk);
         @(negedge clk);
         bin_i = 20'($urandom);
         n = 0;
         while (!done_o && n < 40) begin
            @(negedge clk);
            n++;
         end
         checks++;
         if (n != 21 || bcd_o !== exp_bcd(v) || ovf_o !== exp_ovf(v)) begin
            failures++;
            $display("FAIL b2b i=%0d v=%0d lat=%0d got=%h/%b exp=%h/%b",
                     i, v, n, bcd_o, ovf_o, exp_bcd(v), exp_ovf(v));
         end
      end
      start_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int n, dones, lat, bb, sb;
      @(negedge clk);
      start_i = 1'b1;
      bin_i   = 20'd555555;
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
      for (n = 0; n < 10; n++) @(negedge clk);
      rstn = 1'b0;
      #1;
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || bcd_o !== 24'h0
          || ovf_o !== 1'b0 || digit_valid_o !== 6'b111111) begin
         failures++;
         $display("FAIL mid_reset got busy=%b done=%b bcd=%h ovf=%b dv=%b",
                  busy_o, done_o, bcd_o, ovf_o, digit_valid_o);
      end
      @(negedge clk);
      rstn  = 1'b1;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done_o || busy_o) dones++;
      end
      checks++;
      if (dones != 0) begin
         failures++;
         $display("FAIL mid_reset_quiet got=%0d active cycles exp=0", dones);
      end
      convert(20'd65535, lat, bb, sb);
      checks++;
      if (lat != 21 || bcd_o !== 24'h065535 || ovf_o !== 1'b0) begin
         failures++;
         $display("FAIL after_reset got lat=%0d bcd=%h exp 21 065535",
                  lat, bcd_o);
      end
      checks++;
      if (digit_valid_o !== exp_dv(65535)) begin
         failures++;
         $display("FAIL after_reset_dv got=%b exp=%b",
                  digit_valid_o, exp_dv(65535));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundary();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
